fetch_line_buffer: RTL and testbench
====================================

Name: fetch_line_buffer

Overview:
- Sits between the line-fill path (VA-to-PA translation plus addr_to_data) and Decode.
- Requests one 64-byte instruction line at a time, captures it, and presents its 32-bit instructions to Decode one per accepted handshake, in PC order.
- Starts a new line fetch automatically when the current line is exhausted.
- Restarts from an arbitrary PC on redirect (entry point or taken branch). Stale fills are discarded.

Parameters:
- ADDRESS_WIDTH, 64, PC and fill address width
- INSTRUCTION_WIDTH, 32, instruction word width
- LINE_WIDTH, 512, fill line width in bits (BUS_DATA_WIDTH*8)

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-low reset
- in_redirect_valid  input  1  load new PC, flush buffered line
- in_redirect_pc  input  ADDRESS_WIDTH  redirect target; bits [1:0] ignored
- out_fill_req  output  1  line fill request, held until a response arrives
- out_fill_addr  output  ADDRESS_WIDTH  line base address, bits [5:0] always 0
- in_fill_valid  input  1  one-cycle pulse: in_fill_data holds the requested line
- in_fill_data  input  LINE_WIDTH  line; word i = bits [32i+31:32i]
- out_valid  output  1  instruction presented to Decode
- out_instruction_bits  output  INSTRUCTION_WIDTH  presented instruction
- out_pc  output  ADDRESS_WIDTH  address of presented instruction
- out_pcplus1  output  ADDRESS_WIDTH  out_pc + 4
- in_ready  input  1  Decode accepts; a transfer ("fire") is out_valid & in_ready

Behaviour:
- States: IDLE, FILL, ISSUE. Internal registers: pc, line, drop.
- Reset (reset=0, asynchronous):
  - state=IDLE; pc=0; line=0; drop=0.
  - All outputs 0.
  - Effective immediately, regardless of clk.
- IDLE:
  - out_fill_req=0, out_valid=0.
  - Redirect: pc <= {in_redirect_pc[63:2],2'b00} and go to FILL.
- FILL:
  - out_fill_req=1; out_fill_addr={pc[63:6],6'b0}, driven from a register.
  - in_fill_valid with drop=0: line <= in_fill_data; go to ISSUE. out_valid rises the next cycle.
  - in_fill_valid with drop=1: discard the data, clear drop, stay in FILL.
- ISSUE:
  - out_valid=1; out_instruction_bits=line word pc[5:2]; out_pc=pc; out_pcplus1=pc+4.
  - Outputs are held stable while in_ready=0.
  - On fire: pc <= pc+4.
  - Fire with pc[5:2]==15: go to FILL with the next line base (+64). out_valid=0 the next cycle.
  - Any other fire: stay in ISSUE and present the next word the following cycle.
- Redirect, any non-IDLE state:
  - Highest priority. A fire in the same cycle is still accepted by Decode, but pc takes the redirect value.
  - Next state is FILL; out_valid=0 the next cycle.
  - If redirect arrives in FILL with no in_fill_valid that cycle, set drop=1, because the outstanding response is stale.
  - If redirect and in_fill_valid coincide, discard the data and leave drop=0, because the stale response is consumed.
  - Repeated redirects while drop=1 keep drop=1; only one response is outstanding.
- Latency:
  - redirect at cycle t: out_fill_req/out_fill_addr updated at t+1.
  - in_fill_valid at cycle u: first instruction valid at u+1.
  - Sustained throughput is one instruction per cycle within a line.
- Arithmetic: pc and address increments wrap modulo 2^ADDRESS_WIDTH. A line at 0xFFFF_FFFF_FFFF_FFC0 is followed by a request for address 0.
- in_fill_valid in IDLE or ISSUE is ignored.
- Instruction 0x00000000 is issued normally; halt detection is downstream.

Decomposition:
- Shared package fetch_pkg:
  - state enum fetch_state_e {IDLE, FILL, ISSUE}
  - LINE_BYTES=64, WORDS_PER_LINE=16, WORD_OFFSET_BITS=4, LINE_OFFSET_BITS=6
- No sub-module. Word selection is a single indexed part-select of line by pc[5:2].

Test Plan:
- Sequential line: reset release, redirect 0x1000 → out_fill_req=1, out_fill_addr=0x1000. Fill with word i=0x100+i, in_ready=1 → 16 consecutive fires with pc 0x1000..0x103C and instr 0x100..0x10F. The next cycle shows out_fill_req with addr 0x1040.
- Mid-line entry: redirect 0x2039 → fill addr 0x2000 → two instructions, words 14 and 15, at pc 0x2038 and 0x203C → request at 0x2040.
- Stall: in_ready=0 for 5 cycles while pc=0x100C → out_valid, out_pc and out_instruction_bits unchanged. Resume yields 0x1010 next.
- Stale fill: redirect 0x3000 while FILL awaits 0x1040 → first in_fill_valid discarded (no out_valid). The second fill is issued at pc 0x3000.
- Redirect during issue: redirect 0x4000 coincident with fire at 0x1004 → no instruction at 0x1008 ever valid; fill request for 0x4000 next cycle.
- Async reset mid-ISSUE: reset=0 between clock edges → out_valid, out_fill_req and out_pc read 0 before the next posedge. After release the block stays IDLE until a redirect.

Source files
------------

// File: rtl/fetch_line_buffer_pkg.sv
// rtl/fetch_line_buffer_pkg.sv - shared types and line geometry for the fetch line buffer
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

  localparam int LINE_BYTES       = 64;
  localparam int WORDS_PER_LINE   = 16;
  localparam int WORD_OFFSET_BITS = 4;
  localparam int LINE_OFFSET_BITS = 6;

endpackage

// File: rtl/fetch_line_buffer.sv
// rtl/fetch_line_buffer.sv - fetches one 64-byte line at a time and issues its words to decode in PC order
module fetch_line_buffer
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH     = 64,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int LINE_WIDTH        = 512
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]     in_redirect_pc,
  output logic                         out_fill_req,
  output logic [ADDRESS_WIDTH-1:0]     out_fill_addr,
  input  logic                         in_fill_valid,
  input  logic [LINE_WIDTH-1:0]        in_fill_data,
  output logic                         out_valid,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction_bits,
  output logic [ADDRESS_WIDTH-1:0]     out_pc,
  output logic [ADDRESS_WIDTH-1:0]     out_pcplus1,
  input  logic                         in_ready
);

  fetch_state_e state;
  fetch_state_e state_next;

  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] fill_addr;
  logic [LINE_WIDTH-1:0]    line;
  logic                     drop;

  logic                        fire;
  logic                        last_word;
  logic [WORD_OFFSET_BITS-1:0] word_index;
  logic [ADDRESS_WIDTH-1:0]    redirect_pc_aligned;
  logic [ADDRESS_WIDTH-1:0]    redirect_line_base;
  logic [ADDRESS_WIDTH-1:0]    next_line_base;

  assign fire                = out_valid & in_ready;
  assign word_index          = pc[LINE_OFFSET_BITS-1:2];
  assign last_word           = (word_index == WORD_OFFSET_BITS'(WORDS_PER_LINE - 1));
  assign redirect_pc_aligned = in_redirect_pc & ~ADDRESS_WIDTH'(3);
  assign redirect_line_base  = {redirect_pc_aligned[ADDRESS_WIDTH-1:LINE_OFFSET_BITS],
                                {LINE_OFFSET_BITS{1'b0}}};
  assign next_line_base      = {pc[ADDRESS_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}}
                               + ADDRESS_WIDTH'(LINE_BYTES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_redirect_valid) state_next = FILL;
      end
      FILL: begin
        if (in_redirect_valid) state_next = FILL;
        else if (in_fill_valid && !drop) state_next = ISSUE;
      end
      ISSUE: begin
        if (in_redirect_valid) state_next = FILL;
        else if (fire && last_word) state_next = FILL;
      end
      default: state_next = IDLE;
    endcase
  end

  // drop marks the single outstanding response as stale after a redirect during FILL
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= '0;
      fill_addr <= '0;
      line      <= '0;
      drop      <= 1'b0;
    end else if (in_redirect_valid) begin
      pc        <= redirect_pc_aligned;
      fill_addr <= redirect_line_base;
      if (state == FILL) drop <= ~in_fill_valid;
    end else begin
      case (state)
        FILL: begin
          if (in_fill_valid) begin
            if (drop) drop <= 1'b0;
            else      line <= in_fill_data;
          end
        end
        ISSUE: begin
          if (fire) begin
            pc <= pc + ADDRESS_WIDTH'(4);
            if (last_word) fill_addr <= next_line_base;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_fill_addr = fill_addr;

  always_comb begin
    out_fill_req         = 1'b0;
    out_valid            = 1'b0;
    out_instruction_bits = '0;
    out_pc               = '0;
    out_pcplus1          = '0;
    case (state)
      FILL: out_fill_req = 1'b1;
      ISSUE: begin
        out_valid            = 1'b1;
        out_instruction_bits = line[{word_index, 5'b00000} +: INSTRUCTION_WIDTH];
        out_pc               = pc;
        out_pcplus1          = pc + ADDRESS_WIDTH'(4);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// tb/tb_fetch_line_buffer.sv - randomized scoreboard bench for fetch_line_buffer
module tb_fetch_line_buffer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_redirect_valid = 1'b0;
  logic [63:0]  in_redirect_pc = '0;
  logic         out_fill_req;
  logic [63:0]  out_fill_addr;
  logic         in_fill_valid = 1'b0;
  logic [511:0] in_fill_data = '0;
  logic         out_valid;
  logic [31:0]  out_instruction_bits;
  logic [63:0]  out_pc;
  logic [63:0]  out_pcplus1;
  logic         in_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_line_buffer dut (
    .clk                  (clk),
    .reset                (reset),
    .in_redirect_valid    (in_redirect_valid),
    .in_redirect_pc       (in_redirect_pc),
    .out_fill_req         (out_fill_req),
    .out_fill_addr        (out_fill_addr),
    .in_fill_valid        (in_fill_valid),
    .in_fill_data         (in_fill_data),
    .out_valid            (out_valid),
    .out_instruction_bits (out_instruction_bits),
    .out_pc               (out_pc),
    .out_pcplus1          (out_pcplus1),
    .in_ready             (in_ready)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int fires = 0;

  // Memory image: every word's content is a hash of its own byte address
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] h;
    h = a * 64'h9E37_79B9_7F4A_7C15;
    return h[63:32] ^ h[31:0];
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Fill responder and reference model state, owned by the driver
  logic [63:0] model_pc = '0;
  logic        pending = 1'b0;
  logic [63:0] lat_addr = '0;
  int          lat_gen = 0;
  int          gen = 0;
  int          delay = 0;
  int          tgt_idx = 0;
  logic [63:0] directed [5] = '{64'h1000, 64'h2039, 64'hFFFF_FFFF_FFFF_FFF8, 64'h3000, 64'h4000};

  function automatic logic [63:0] next_target();
    logic [63:0] t;
    if (tgt_idx < 5) begin
      t = directed[tgt_idx];
      tgt_idx++;
    end else begin
      case ($urandom_range(0, 3))
        0:       t = {$urandom, $urandom};
        1:       t = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
        2:       t = 64'($urandom_range(0, 8191));
        default: t = {$urandom, $urandom} | 64'h38;
      endcase
    end
    return t;
  endfunction

  task automatic drive_cycle(input bit force_redir, input int redir_pct, input int ready_pct);
    logic        redir;
    logic [63:0] base;
    @(posedge clk);
    #1;
    in_fill_valid     = 1'b0;
    in_redirect_valid = 1'b0;
    if (!pending && out_fill_req) begin
      pending  = 1'b1;
      lat_addr = out_fill_addr;
      lat_gen  = gen;
      delay    = $urandom_range(0, 3);
      check64("fill_addr", out_fill_addr, {model_pc[63:6], 6'b0});
    end
    redir    = force_redir || ($urandom_range(0, 99) < redir_pct);
    in_ready = ($urandom_range(0, 99) < ready_pct);
    if (pending) begin
      if (delay == 0) begin
        in_fill_valid = 1'b1;
        for (int i = 0; i < 16; i++) in_fill_data[32*i +: 32] = mem_word(lat_addr + 64'(4 * i));
        pending = 1'b0;
        if (!redir && gen == lat_gen) begin
          base = {model_pc[63:6], 6'b0};
          for (int w = int'(model_pc[5:2]); w < 16; w++)
            exp_q.push_back('{pc: base + 64'(4 * w), instr: mem_word(base + 64'(4 * w))});
          model_pc = base + 64'd64;
        end
      end else begin
        delay--;
      end
    end else if (!out_fill_req && $urandom_range(0, 15) == 0) begin
      in_fill_valid = 1'b1;
      in_fill_data  = {16{$urandom}};
    end
    if (redir) begin
      in_redirect_valid = 1'b1;
      in_redirect_pc    = next_target();
      model_pc          = {in_redirect_pc[63:2], 2'b00};
      gen++;
    end
  endtask

  // Monitor: pops the scoreboard on every fire, checks stalls hold outputs
  initial begin
    exp_t        e;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (prev_stall) begin
          check64("stall_valid", 64'(out_valid), 64'd1);
          check64("stall_pc", out_pc, prev_pc);
          check64("stall_instr", 64'(out_instruction_bits), 64'(prev_instr));
        end
        if (out_valid && in_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_fire: got pc %h instr %h, required no instruction", out_pc, out_instruction_bits);
          end else begin
            e = exp_q.pop_front();
            check64("fire_pc", out_pc, e.pc);
            check64("fire_instr", 64'(out_instruction_bits), 64'(e.instr));
            check64("fire_pcplus1", out_pcplus1, e.pc + 64'd4);
            fires++;
          end
        end
        if (in_redirect_valid) exp_q.delete();
        prev_stall = out_valid && !in_ready && !in_redirect_valid;
        prev_pc    = out_pc;
        prev_instr = out_instruction_bits;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    int n;
    int fires_before;
    #1 reset = 1'b0;
    #1;
    check64("reset_valid", 64'(out_valid), 64'd0);
    check64("reset_fill_req", 64'(out_fill_req), 64'd0);
    check64("reset_pc", out_pc, 64'd0);
    check64("reset_fill_addr", out_fill_addr, 64'd0);
    #20 reset = 1'b1;

    drive_cycle(1'b1, 0, 75);
    for (int i = 0; i < 1500; i++) drive_cycle(1'b0, 2, 75);
    for (int i = 0; i < 800; i++) drive_cycle(1'b0, 2, 20);

    n = 0;
    while (!out_valid && n < 200) begin
      drive_cycle(1'b0, 0, 30);
      n++;
    end
    check64("reach_issue", 64'(out_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    check64("async_reset_valid", 64'(out_valid), 64'd0);
    check64("async_reset_fill_req", 64'(out_fill_req), 64'd0);
    check64("async_reset_pc", out_pc, 64'd0);
    exp_q.delete();
    pending           = 1'b0;
    in_redirect_valid = 1'b0;
    in_fill_valid     = 1'b0;
    in_ready          = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_ready = 1'b1;
      check64("idle_fill_req", 64'(out_fill_req), 64'd0);
      check64("idle_valid", 64'(out_valid), 64'd0);
    end

    fires_before = fires;
    drive_cycle(1'b1, 0, 100);
    for (int i = 0; i < 800; i++) drive_cycle(1'b0, 1, 100);
    vectors++;
    if (fires - fires_before < 200) begin
      miscompares++;
      $display("FAIL progress: got %0d fires, required at least 200", fires - fires_before);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
